gcu_task_scheduler: RTL

//  Dependency-driven dispatcher for NodeTask_t descriptors of the multifrontal elimination tree.

---
 rtl/gcu_task_scheduler_if.sv | 50 +++++
 rtl/gcu_task_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gcu_task_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : gcu_task_pkg / gcu_task_if
//  Description : Node descriptor type and the load / dispatch / completion
//                handshake bundle of the GCU task scheduler.
//  Revision    : 1.0  initial release
// ============================================================================

package gcu_task_pkg;
    localparam int NODE_ID_W = 4;
    // Node id all-ones is the root marker, so the table holds one entry fewer.
    localparam int NUM_NODES = 2**NODE_ID_W - 1;
    localparam int CNT_W     = $clog2(NUM_NODES + 1);
    localparam int PAYLOAD_W = 16;

    typedef struct packed {
        logic [NODE_ID_W-1:0] node_id;
        logic [NODE_ID_W-1:0] parent_id;
        logic [CNT_W-1:0]     children_count;
        logic [PAYLOAD_W-1:0] front_size;
    } NodeTask_t;
endpackage

interface gcu_task_if;
    import gcu_task_pkg::*;

    logic                 load_valid;
    logic                 load_ready;
    NodeTask_t            load_task;
    logic                 disp_valid;
    logic                 disp_ready;
    NodeTask_t            disp_task;
    logic                 done_valid;
    logic                 done_ready;
    logic [NODE_ID_W-1:0] done_node_id;

    // Host loader and compute engine side
    modport master (
        output load_valid, load_task, disp_ready, done_valid, done_node_id,
        input  load_ready, disp_valid, disp_task, done_ready
    );

    // Scheduler side
    modport slave (
        input  load_valid, load_task, disp_ready, done_valid, done_node_id,
        output load_ready, disp_valid, disp_task, done_ready
    );
endinterface

`default_nettype wire

// File: rtl/gcu_task_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gcu_task_scheduler
//  Description : Dependency-driven dispatcher for elimination-tree nodes.
//                Leaves dispatch first; each completion decrements the
//                parent's pending-child count and releases it at zero.
//  Revision    : 1.0  initial release
// ============================================================================

module gcu_task_scheduler
    import gcu_task_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    gcu_task_if.slave        bus,
    output logic             busy,
    output logic             all_done,
    output logic             err,
    output logic [CNT_W-1:0] loaded_cnt,
    output logic [CNT_W-1:0] completed_cnt
);

    localparam logic [NODE_ID_W-1:0] ROOT_ID   = {NODE_ID_W{1'b1}};
    localparam logic [NODE_ID_W-1:0] ID_LIMIT  = NODE_ID_W'(NUM_NODES);
    localparam logic [NODE_ID_W-1:0] LAST_SLOT = NODE_ID_W'(NUM_NODES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           r_state;
    NodeTask_t            r_tbl     [NUM_NODES];
    logic [CNT_W-1:0]     r_pending [NUM_NODES];
    logic [NUM_NODES-1:0] r_valid;
    logic [NUM_NODES-1:0] r_disp;
    logic [NUM_NODES-1:0] r_comp;
    logic [NODE_ID_W-1:0] r_fifo    [NUM_NODES];
    logic [NODE_ID_W-1:0] r_head;
    logic [NODE_ID_W-1:0] r_tail;
    logic [CNT_W-1:0]     r_fifo_cnt;
    logic                 r_err;
    logic [CNT_W-1:0]     r_loaded;
    logic [CNT_W-1:0]     r_completed;

    function automatic logic [NODE_ID_W-1:0] next_slot(input logic [NODE_ID_W-1:0] ptr);
        return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic w_start_ok;
    logic w_run_ok;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_run_ok   = run && (r_state == S_LOAD);

    // Load path: an id equal to the root marker is outside the table.
    logic                 w_load_fire;
    logic [NODE_ID_W-1:0] w_ld_id;
    logic                 w_ld_in_range;
    logic                 w_ld_accept;
    logic                 w_ld_leaf;
    assign w_load_fire   = bus.load_valid && (r_state == S_LOAD);
    assign w_ld_id       = bus.load_task.node_id;
    assign w_ld_in_range = w_ld_id < ID_LIMIT;
    assign w_ld_accept   = w_load_fire && w_ld_in_range && !r_valid[w_ld_id];
    assign w_ld_leaf     = (bus.load_task.children_count == '0);

    // Completion path; table lookups use clamped indices so that an
    // out-of-range id never addresses past the arrays.
    logic                 w_done_fire;
    logic [NODE_ID_W-1:0] w_dn_id;
    logic                 w_dn_in_range;
    logic [NODE_ID_W-1:0] w_dn_idx;
    logic                 w_dn_legal;
    logic [NODE_ID_W-1:0] w_par;
    logic                 w_par_is_node;
    logic [NODE_ID_W-1:0] w_par_idx;
    logic [CNT_W-1:0]     w_par_pend;
    logic                 w_par_bad;
    logic                 w_par_dec;
    logic                 w_par_push;
    assign w_done_fire   = bus.done_valid && (r_state == S_RUN);
    assign w_dn_id       = bus.done_node_id;
    assign w_dn_in_range = w_dn_id < ID_LIMIT;
    assign w_dn_idx      = w_dn_in_range ? w_dn_id : '0;
    assign w_dn_legal    = w_done_fire && w_dn_in_range && r_disp[w_dn_idx] && !r_comp[w_dn_idx];
    assign w_par         = r_tbl[w_dn_idx].parent_id;
    assign w_par_is_node = (w_par != ROOT_ID);
    assign w_par_idx     = w_par_is_node ? w_par : '0;
    assign w_par_pend    = r_pending[w_par_idx];
    // A completion naming an unloaded parent, or one with no children left, is a protocol error.
    assign w_par_bad     = w_par_is_node && (!r_valid[w_par_idx] || (w_par_pend == '0));
    assign w_par_dec     = w_dn_legal && w_par_is_node && !w_par_bad;
    assign w_par_push    = w_par_dec && (w_par_pend == CNT_W'(1));

    logic w_err_set;
    assign w_err_set = (w_load_fire && !w_ld_accept)
                     || (w_done_fire && !w_dn_legal)
                     || (w_dn_legal && w_par_bad);

    // ------------------------------------------------------------------
    // Ready FIFO: loads and completions never fire in the same state, so
    // at most one push per cycle.
    // ------------------------------------------------------------------
    logic                 w_fifo_empty;
    logic                 w_disp_valid;
    logic [NODE_ID_W-1:0] w_head_id;
    logic                 w_pop;
    logic                 w_push;
    logic [NODE_ID_W-1:0] w_push_id;
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_disp_valid = (r_state == S_RUN) && !w_fifo_empty;
    assign w_head_id    = r_fifo[r_head];
    assign w_pop        = w_disp_valid && bus.disp_ready;
    assign w_push       = (w_ld_accept && w_ld_leaf) || w_par_push;
    assign w_push_id    = w_ld_accept ? w_ld_id : w_par_idx;

    // Top-level phase sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_ok) r_state <= S_LOAD;
                S_LOAD:  if (w_run_ok) r_state <= S_RUN;
                S_RUN:   if (r_completed == r_loaded) r_state <= S_DONE;
                S_DONE:  if (w_start_ok) r_state <= S_LOAD;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Descriptor table and pending-child counts; validity is tracked separately,
    // so these arrays never need clearing
    always_ff @(posedge clk) begin
        if (w_ld_accept) begin
            r_tbl[w_ld_id]     <= bus.load_task;
            r_pending[w_ld_id] <= bus.load_task.children_count;
        end
        if (w_par_dec) begin
            r_pending[w_par_idx] <= w_par_pend - 1'b1;
        end
    end

    // Per-node status bitmaps, progress counters and sticky error
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_valid     <= '0;
            r_disp      <= '0;
            r_comp      <= '0;
            r_loaded    <= '0;
            r_completed <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_ld_accept) begin
                r_valid[w_ld_id] <= 1'b1;
                r_loaded         <= r_loaded + 1'b1;
            end
            if (w_pop) begin
                r_disp[w_head_id] <= 1'b1;
            end
            if (w_dn_legal) begin
                r_comp[w_dn_idx] <= 1'b1;
                r_completed      <= r_completed + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Ready FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_tail] <= w_push_id;
                r_tail         <= next_slot(r_tail);
            end
            if (w_pop) begin
                r_head <= next_slot(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.load_ready = (r_state == S_LOAD);
    assign bus.done_ready = (r_state == S_RUN);
    assign bus.disp_valid = w_disp_valid;
    assign bus.disp_task  = w_disp_valid ? r_tbl[w_head_id] : '0;
    assign busy           = (r_state == S_LOAD) || (r_state == S_RUN);
    assign all_done       = (r_state == S_DONE);
    assign err            = r_err;
    assign loaded_cnt     = r_loaded;
    assign completed_cnt  = r_completed;

endmodule

`default_nettype wire
